// File: rtl/mod_pkg.sv
// Shared types and helpers for the serial divisibility checker family.
// Holds the default modulus, the remainder-width rule and a saturating increment.
package mod_pkg;

    localparam int DIVISOR_DEFAULT = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } frame_state_t;

    // Remainder width is ceil(log2(divisor)), never narrower than one bit.
    function automatic int rem_width(input int divisor);
        int w;
        w = $clog2(divisor);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/serial_mod_step.sv
// One bit of MSB-first remainder update: rem_out = (2*rem_in + data_bit) mod DIVISOR.
// Uses a single conditional subtract; valid because rem_in < DIVISOR.
module serial_mod_step
    import mod_pkg::*;
#(
    parameter int DIVISOR = DIVISOR_DEFAULT,
    parameter int REM_W   = rem_width(DIVISOR)
) (
    input  logic [REM_W-1:0] rem_in,
    input  logic             data_bit,
    output logic [REM_W-1:0] rem_out
);

    localparam logic [REM_W:0] DIV = (REM_W + 1)'(DIVISOR);

    logic [REM_W:0] t;
    logic [REM_W:0] t_sub;

    always_comb begin
        t       = {rem_in, data_bit};
        t_sub   = t - DIV;
        rem_out = (t >= DIV) ? t_sub[REM_W-1:0] : t[REM_W-1:0];
    end

endmodule

// File: rtl/serial_mod_checker.sv
// Bit-serial MSB-first "frame value mod DIVISOR" checker with a one-slot result buffer.
// Optional macro SERIAL_MOD_FRAME_COUNT_EN adds saturating frame_count / mult_count outputs.
module serial_mod_checker
    import mod_pkg::*;
#(
    parameter int DIVISOR = DIVISOR_DEFAULT,
    parameter int LEN_W   = 8,
    localparam int REM_W  = rem_width(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mult,
    output logic [REM_W-1:0] out_rem,
    output logic [LEN_W-1:0] out_len
`ifdef SERIAL_MOD_FRAME_COUNT_EN
    ,
    output logic [15:0]      mult_count,
    output logic [15:0]      frame_count
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    frame_state_t     state;
    frame_state_t     state_next;
    logic [REM_W-1:0] rem;
    logic [LEN_W-1:0] len;
    logic [REM_W-1:0] rem_base;
    logic [LEN_W-1:0] len_base;
    logic [REM_W-1:0] rem_next;
    logic [LEN_W-1:0] len_next;
    logic             acc;
    logic             load;
    logic             next_is_mult;

    // Draining the slot frees it in the same cycle, so a new result may refill it.
    assign in_ready     = !out_valid || out_ready;
    assign acc          = in_valid && in_ready;
    assign load         = acc && in_last && !clear;
    assign next_is_mult = (rem_next == '0);

    // A fresh frame always starts from zero state, whatever the registers hold.
    assign rem_base = (state == IDLE) ? '0 : rem;
    assign len_base = (state == IDLE) ? '0 : len;
    assign len_next = LEN_W'(sat_inc(32'(len_base), 32'(LEN_MAX)));

    serial_mod_step #(
        .DIVISOR (DIVISOR),
        .REM_W   (REM_W)
    ) u_step (
        .rem_in   (rem_base),
        .data_bit (in_bit),
        .rem_out  (rem_next)
    );

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (acc) begin
            state_next = in_last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame accumulation; clear wins over a simultaneous accept and drops that bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            len <= '0;
        end else if (clear) begin
            rem <= '0;
            len <= '0;
        end else if (acc) begin
            if (in_last) begin
                rem <= '0;
                len <= '0;
            end else begin
                rem <= rem_next;
                len <= len_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mult  <= 1'b0;
            out_rem   <= '0;
            out_len   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_mult  <= next_is_mult;
            out_rem   <= rem_next;
            out_len   <= len_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SERIAL_MOD_FRAME_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            mult_count  <= '0;
        end else if (load) begin
            frame_count <= 16'(sat_inc(32'(frame_count), 32'h0000_FFFF));
            if (next_is_mult) begin
                mult_count <= 16'(sat_inc(32'(mult_count), 32'h0000_FFFF));
            end
        end
    end
`endif

endmodule
